pe_ws_db: RTL

- Next-generation weight-stationary INT MAC processing element for the systolic array.
- Adds to the single-register PE:
  - a double-buffered weight (shadow + active), loaded via a column-wise weight shift chain so the next tile's weights stream in while the current tile computes;
  - valid-tagged, registered activation forwarding;
  - signed/unsigned operand mode;
  - optional saturating accumulation with a sticky overflow flag.
- Instantiated N×M in the array; partial sums flow horizontally, activations and weights flow downward.

---
 rtl/pe_ws_db.sv | 113 +++++++++++
 1 files changed

// File: rtl/pe_ws_db.sv
// ---------------------------------------------------------------------------
// pe_ws_db: weight-stationary integer MAC processing element with a
// double-buffered weight, for use in an N x M systolic array.
//
// Weights stream down each column through the shadow register. The shadow
// register loads whenever w_valid_in is high. w_swap copies the shadow
// weight into the active weight, so the next tile's weights can be loaded
// while the current tile is still computing. Activations and their valid
// tags are registered and forwarded downward. Partial sums flow left to
// right with a latency of one cycle.
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   en                        global stall; when it is 0, every register holds
//   signed_mode               1 = signed x signed, 0 = unsigned x unsigned
//   w_in / w_valid_in         weight chain input and its shift strobe
//   w_out / w_valid_out       shadow weight and the registered strobe, to the PE below
//   w_swap                    active_w <= shadow_w
//   act_in / act_valid_in     activation input and its valid tag
//   act_out / act_valid_out   registered activation and valid tag, to the PE below
//   acc_in / clear_acc        partial sum from the left; clear_acc replaces it with 0
//   acc_out / acc_valid_out   registered partial sum and its new-result flag
//   ovf                       sticky overflow / saturation flag
// ---------------------------------------------------------------------------
module pe_ws_db #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,   // must be >= 2*DATA_W+1
    parameter int SAT_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              signed_mode,
    input  logic [DATA_W-1:0] w_in,
    input  logic              w_valid_in,
    output logic [DATA_W-1:0] w_out,
    output logic              w_valid_out,
    input  logic              w_swap,
    input  logic [DATA_W-1:0] act_in,
    input  logic              act_valid_in,
    output logic [DATA_W-1:0] act_out,
    output logic              act_valid_out,
    input  logic [ACC_W-1:0]  acc_in,
    input  logic              clear_acc,
    output logic [ACC_W-1:0]  acc_out,
    output logic              acc_valid_out,
    output logic              ovf
);

    logic [DATA_W-1:0] shadow_w_reg;
    logic [DATA_W-1:0] active_w_reg;

    // Both operands are widened by one bit. The extra bit is a sign bit only
    // in signed mode, so a single signed multiplier serves both modes.
    logic signed [DATA_W:0]     act_x;
    logic signed [DATA_W:0]     w_x;
    logic signed [2*DATA_W+1:0] prod;
    logic signed [ACC_W:0]      prod_ext;
    logic signed [ACC_W:0]      acc_sel_ext;
    logic signed [ACC_W:0]      sum;
    logic                       overflow;
    logic [ACC_W-1:0]           sat_val;
    logic [ACC_W-1:0]           acc_result;

    assign act_x = $signed({signed_mode & act_in[DATA_W-1], act_in});
    assign w_x   = $signed({signed_mode & active_w_reg[DATA_W-1], active_w_reg});
    assign prod  = act_x * w_x;

    // The size cast of a signed value sign-extends it. An unsigned-mode
    // product is non-negative, so its widened MSB is already 0.
    assign prod_ext = (ACC_W+1)'(prod);

    // acc_in is always treated as a signed ACC_W value, even in unsigned mode.
    assign acc_sel_ext = clear_acc ? '0 : $signed({acc_in[ACC_W-1], acc_in});
    assign sum         = acc_sel_ext + prod_ext;

    // If the two top bits of the (ACC_W+1)-bit sum differ, the sum does not
    // fit in ACC_W signed bits.
    assign overflow   = sum[ACC_W] ^ sum[ACC_W-1];
    assign sat_val    = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    assign acc_result = ((SAT_EN != 0) && overflow) ? sat_val : sum[ACC_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_w_reg  <= '0;
            active_w_reg  <= '0;
            w_valid_out   <= 1'b0;
            act_out       <= '0;
            act_valid_out <= 1'b0;
            acc_out       <= '0;
            acc_valid_out <= 1'b0;
            ovf           <= 1'b0;
        end else if (en) begin
            // Nonblocking assignment makes a swap in the same cycle as a
            // shift take the old shadow value.
            if (w_valid_in) shadow_w_reg <= w_in;
            if (w_swap)     active_w_reg <= shadow_w_reg;
            w_valid_out   <= w_valid_in;
            act_out       <= act_in;
            act_valid_out <= act_valid_in;
            acc_valid_out <= act_valid_in;
            if (act_valid_in) begin
                acc_out <= acc_result;
                // Starting a new accumulation clears the sticky flag, unless
                // that same cycle overflows.
                ovf     <= clear_acc ? overflow : (ovf | overflow);
            end
        end
    end

    assign w_out = shadow_w_reg;

endmodule
